onehot_rr_arbiter: RTL and testbench
====================================

Name: onehot_rr_arbiter

Overview:
Upstream stage for the 8-to-3 encoder. Latches sporadic request pulses from up to 8 sources. Issues exactly one one-hot grant at a time under round-robin priority, with a valid/ready handshake. The gnt_o vector is guaranteed one-hot or zero, which is exactly the input class the encoder decodes correctly.

Parameters:
N, 8, number of request sources; fixed at 8 to match the 3-bit encoder downstream
PTR_W, 3, width of round-robin pointer, equal to log2(N); derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_i  input  N  request pulses or levels; bit i = source i wants service
gnt_o  output  N  one-hot grant vector; all-zero when gnt_valid_o=0
gnt_valid_o  output  1  gnt_o holds a valid grant
gnt_ready_i  input  1  downstream accepts gnt_o this cycle
pending_o  output  N  current latched-pending vector (debug/status)
busy_o  output  1  OR of pending_o, or gnt_valid_o

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: gnt_o=0, gnt_valid_o=0, pending_o=0, busy_o=0, ptr=0, state=IDLE.
- Pending latch: pending <= (pending & ~clr) | req_i each cycle.
  - clr is the one-hot granted bit when gnt_valid_o && gnt_ready_i, otherwise 0.
  - Set wins: if req_i[k]=1 in the same cycle pending[k] is cleared by acceptance, pending[k] stays 1.
- Pick function: scan registered pending from index ptr upward, wrapping N-1 to 0. The first set bit wins. Result is a one-hot vector, or zero if pending=0.
- FSM states:
  - IDLE: gnt_valid_o=0, gnt_o=0.
    - If pending!=0: load gnt_o=pick(pending), go OFFER.
    - Otherwise stay IDLE.
  - OFFER: gnt_valid_o=1; gnt_o held stable while gnt_ready_i=0. New requests never alter an offered grant.
    - On gnt_ready_i=1: ptr <= (granted index + 1) mod N.
    - Then let rem = pending & ~gnt_o (registered values; excludes this cycle's req_i). If rem!=0, load gnt_o=pick from rem using the new ptr and stay OFFER. Otherwise go IDLE.
- Latency: req_i high before edge k → pending set at edge k → gnt_valid_o high after edge k+1, i.e. 2 cycles.
- Throughput: back-to-back grants, one per cycle, while gnt_ready_i=1 and pending is non-empty.
- gnt_ready_i is ignored when gnt_valid_o=0.
- Repeated req_i on an already-pending bit: idempotent, no counting, no overflow.
- Reset mid-OFFER: grant dropped, pending cleared, ptr=0, IDLE on the next cycle.
- Invariant: the popcount of gnt_o is at most 1 at all times.

Decomposition:
- Shared package: constant N=8, PTR_W=3; state enum {IDLE, OFFER}.
- Sub-module rr_pick: combinational rotate-priority picker. Inputs are a vector and ptr; outputs are a one-hot vector and a found flag. The top instantiates it once and feeds it a pending or rem select.

Test Plan:
1. After reset, req_i=8'b00000100 for 1 cycle, gnt_ready_i=1 -> gnt_valid_o=1 with gnt_o=8'b00000100 exactly 2 cycles later for 1 cycle; pending_o=0 and busy_o=0 afterwards.
2. req_i=8'hFF for 1 cycle, gnt_ready_i=1, ptr=0 -> gnt_o=01,02,04,08,10,20,40,80 on 8 consecutive cycles, then IDLE.
3. req_i=8'b00100000, gnt_ready_i=0 for 4 cycles, req_i=8'b00000010 pulsed during the stall -> gnt_o stays 8'b00100000. On ready=1 the next grant is 8'b00000010, since ptr=6 wraps to bit 1.
4. Grant bit 7 accepted (ptr=0), then req_i=8'b10000001 -> bit 0 granted before bit 7.
5. pending={3,5}; accept the grant of bit 3 while req_i[3]=1 in the same cycle -> pending_o[3] remains 1; next grant is bit 5, then bit 3.
6. Assert rst while in OFFER with pending=8'hF0 -> after the edge, gnt_valid_o=0, gnt_o=0, pending_o=0, ptr=0; a subsequent req of bit 1 is granted after 2 cycles.

Source files
------------

// File: rtl/onehot_rr_arbiter_pkg.sv
// ============================================================================
// Module : onehot_rr_arbiter_pkg
// Brief  : Shared constants, FSM state type and helpers for the RR arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package onehot_rr_arbiter_pkg;

    localparam int N     = 8;
    localparam int PTR_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // Index of a one-hot vector; result is undefined-free (0) for a zero input.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N-1:0] v);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = r | PTR_W'(i);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// ============================================================================
// Module : onehot_rr_arbiter_rr_pick
// Brief  : Combinational rotate-priority picker: first set bit at or after
//          i_ptr (wrapping) is returned one-hot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onehot_rr_arbiter_rr_pick
    import onehot_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]     i_vec,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic             o_found
);

    logic [PTR_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        o_onehot = '0;
        o_found  = 1'b0;
        w_idx    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            w_idx = i_ptr + PTR_W'(j);
            if (i_vec[w_idx]) begin
                o_onehot        = '0;
                o_onehot[w_idx] = 1'b1;
                o_found         = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
// ============================================================================
// Module : onehot_rr_arbiter
// Brief  : Latches request pulses and issues one-hot round-robin grants with a
//          valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module onehot_rr_arbiter
    import onehot_rr_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         gnt_valid_o,
    input  logic         gnt_ready_i,
    output logic [N-1:0] pending_o,
    output logic         busy_o
);

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     w_gnt_next;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [N-1:0]     r_pending;

    logic             w_accept;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_rem;
    logic [PTR_W-1:0] w_ptr_after;
    logic [N-1:0]     w_pick_vec;
    logic [PTR_W-1:0] w_pick_ptr;
    logic [N-1:0]     w_pick;
    logic             w_found;

    assign w_accept    = (r_state == OFFER) && gnt_ready_i;
    assign w_clr       = w_accept ? r_gnt : '0;
    assign w_rem       = r_pending & ~r_gnt;
    assign w_ptr_after = onehot_to_idx(r_gnt) + PTR_W'(1);

    // While offering, the picker looks ahead at what remains after acceptance.
    assign w_pick_vec  = (r_state == OFFER) ? w_rem       : r_pending;
    assign w_pick_ptr  = (r_state == OFFER) ? w_ptr_after : r_ptr;

    onehot_rr_arbiter_rr_pick u_pick (
        .i_vec    (w_pick_vec),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick),
        .o_found  (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_ptr     <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gnt     <= w_gnt_next;
            r_ptr     <= w_ptr_next;
            r_pending <= (r_pending & ~w_clr) | req_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_ptr_next   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_next   = w_pick;
                    w_state_next = OFFER;
                end
            end
            OFFER: begin
                if (gnt_ready_i) begin
                    w_ptr_next = w_ptr_after;
                    if (w_found) begin
                        w_gnt_next = w_pick;
                    end else begin
                        w_gnt_next   = '0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_gnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_valid_o = (r_state == OFFER);
        gnt_o       = gnt_valid_o ? r_gnt : '0;
        pending_o   = r_pending;
        busy_o      = (|r_pending) | gnt_valid_o;
    end

endmodule

`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
// ============================================================================
// Module : tb_onehot_rr_arbiter
// Brief  : Directed and random stimulus against a set-based arbiter model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_onehot_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_i;
    logic [7:0] gnt_o;
    logic       gnt_valid_o;
    logic       gnt_ready_i;
    logic [7:0] pending_o;
    logic       busy_o;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a set of pending sources, a pointer, and the offer.
    bit [7:0] m_pend;
    int       m_ptr;
    bit       m_valid;
    int       m_idx;

    onehot_rr_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_ready_i (gnt_ready_i),
        .pending_o   (pending_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_from(input bit [7:0] set, input int start);
        for (int j = 0; j < 8; j++) begin
            if (set[(start + j) % 8]) return (start + j) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r, input bit [7:0] q, input bit rd);
        bit [7:0] nxt;
        bit [7:0] rest;
        int       f;
        if (r) begin
            m_pend = '0; m_ptr = 0; m_valid = 0; m_idx = 0;
        end else begin
            nxt = m_pend;
            if (m_valid && rd) nxt[m_idx] = 1'b0;
            nxt = nxt | q;
            if (!m_valid) begin
                f = first_from(m_pend, m_ptr);
                if (f >= 0) begin m_valid = 1; m_idx = f; end
            end else if (rd) begin
                m_ptr = (m_idx + 1) % 8;
                rest = m_pend;
                rest[m_idx] = 1'b0;
                f = first_from(rest, m_ptr);
                if (f >= 0) m_idx = f;
                else m_valid = 0;
            end
            m_pend = nxt;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic [7:0] q, input logic rd);
        logic [7:0] exp_gnt;
        rst = r; req_i = q; gnt_ready_i = rd;
        @(posedge clk);
        model_edge(r, q, rd);
        #1;
        exp_gnt = m_valid ? (8'h01 << m_idx) : 8'h00;
        chk("gnt", gnt_o, exp_gnt);
        chk("valid", {7'd0, gnt_valid_o}, {7'd0, m_valid});
        chk("pending", pending_o, m_pend);
        chk("busy", {7'd0, busy_o}, {7'd0, (m_pend != 0) || m_valid});
        chk("onehot", {7'd0, $countones(gnt_o) <= 1}, 8'd1);
    endtask

    task automatic idle_steps(input int n, input logic rd);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rd);
    endtask

    initial begin
        rst = 1'b1; req_i = '0; gnt_ready_i = 1'b0;
        m_pend = '0; m_ptr = 0; m_valid = 0; m_idx = 0;
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("rst_gnt", gnt_o, 8'h00);
        chk("rst_pend", pending_o, 8'h00);
        chk("rst_busy", {7'd0, busy_o}, 8'h00);

        // Single pulse: grant appears two edges later for one cycle.
        step(1'b0, 8'h04, 1'b1);
        chk("t1_nogrant_yet", {7'd0, gnt_valid_o}, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_grant", gnt_o, 8'h04);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_done_busy", {7'd0, busy_o}, 8'h00);
        idle_steps(2, 1'b1);

        // All sources at once from pointer 0: ascending sweep.
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t2_sweep", gnt_o, 8'h01 << i);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("t2_idle", {7'd0, gnt_valid_o}, 8'h00);

        // Stalled offer stays fixed; pointer wraps past 7 to bit 1.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h20, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t3_stall", gnt_o, 8'h20);
        step(1'b0, 8'h00, 1'b1);
        chk("t3_wrap", gnt_o, 8'h02);
        idle_steps(3, 1'b1);

        // Bit 7 served, pointer back at 0: bit 0 goes before bit 7.
        step(1'b1, 8'h00, 1'b1);
        step(1'b0, 8'h80, 1'b1);
        idle_steps(2, 1'b1);
        step(1'b0, 8'h81, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_bit0_first", gnt_o, 8'h01);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_bit7_next", gnt_o, 8'h80);
        idle_steps(2, 1'b1);

        // Re-request on the accepted bit keeps it pending.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h28, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("t5_offer3", gnt_o, 8'h08);
        step(1'b0, 8'h08, 1'b1);
        chk("t5_pend3", pending_o & 8'h08, 8'h08);
        chk("t5_offer5", gnt_o, 8'h20);
        step(1'b0, 8'h00, 1'b1);
        chk("t5_offer3_again", gnt_o, 8'h08);
        idle_steps(2, 1'b1);

        // Reset during an offer.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'hF0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("t6_rst_valid", {7'd0, gnt_valid_o}, 8'h00);
        step(1'b0, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_regrant", gnt_o, 8'h02);
        idle_steps(2, 1'b1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] q;
            q = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(($urandom_range(0, 63) == 0), q, 1'($urandom));
        end
        idle_steps(20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
